ifu_fetch_ctrl: RTL and testbench

Instruction fetch controller at the front of the core. It holds the architectural PC and issues one instruction-memory request at a time over a valid/ready handshake. It presents each fetched instruction and its PC to the idu, then waits for the exeu to return the resolved next PC (pc_act_trgt) before fetching again. No speculation; one instruction is in flight at a time.

---
 rtl/ifu_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: owns the PC and runs one fetch at a time.
// It waits for the resolved next PC from exeu before issuing the next request.
module ifu_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  halt_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
  input  logic                  imem_rsp_err_i,
  output logic [INST_WIDTH-1:0] instr_idu_o,
  output logic [ADDR_WIDTH-1:0] pc_idu_o,
  output logic                  instr_valid_idu_o,
  input  logic                  instr_ready_idu_i,
  input  logic                  redir_valid_exeu_i,
  input  logic [ADDR_WIDTH-1:0] pc_act_trgt_exeu_i,
  output logic                  fetch_err_o,
  output logic [31:0]           inst_cnt_o
);

  typedef enum logic [2:0] {
    HALT,
    REQ,
    WAIT_RSP,
    HOLD,
    WAIT_EXE,
    ERR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pc_idu_q, pc_idu_d;
  logic                  err_q, err_d;
  logic [31:0]           cnt_q, cnt_d;

  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= HALT;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_idu_q <= RESET_PC;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_idu_q <= pc_idu_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_idu_d = pc_idu_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      HALT: begin
        if (!halt_i) state_d = REQ;
      end
      REQ: begin
        if (imem_req_ready_i) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (imem_rsp_valid_i) begin
          if (imem_rsp_err_i) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            instr_d  = imem_rsp_data_i;
            pc_idu_d = pc_q;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (instr_ready_idu_i) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = WAIT_EXE;
        end
      end
      WAIT_EXE: begin
        if (redir_valid_exeu_i) begin
          pc_d = pc_act_trgt_exeu_i;
          if (pc_act_trgt_exeu_i[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else if (halt_i) begin
            state_d = HALT;
          end else begin
            state_d = REQ;
          end
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  assign imem_req_valid_o  = (state_q == REQ);
  assign imem_req_addr_o   = pc_q;
  assign instr_idu_o       = instr_q;
  assign pc_idu_o          = pc_idu_q;
  assign instr_valid_idu_o = (state_q == HOLD);
  assign fetch_err_o       = err_q;
  assign inst_cnt_o        = cnt_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl.
// Each task drives a scenario and checks hand-computed values inline.
module tb_ifu_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        halt_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic [31:0] instr_idu_o;
  logic [31:0] pc_idu_o;
  logic        instr_valid_idu_o;
  logic        instr_ready_idu_i;
  logic        redir_valid_exeu_i;
  logic [31:0] pc_act_trgt_exeu_i;
  logic        fetch_err_o;
  logic [31:0] inst_cnt_o;

  int errors;
  int checks;
  int cyc;
  int t0;

  ifu_fetch_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .halt_i             (halt_i),
    .imem_req_valid_o   (imem_req_valid_o),
    .imem_req_ready_i   (imem_req_ready_i),
    .imem_req_addr_o    (imem_req_addr_o),
    .imem_rsp_valid_i   (imem_rsp_valid_i),
    .imem_rsp_data_i    (imem_rsp_data_i),
    .imem_rsp_err_i     (imem_rsp_err_i),
    .instr_idu_o        (instr_idu_o),
    .pc_idu_o           (pc_idu_o),
    .instr_valid_idu_o  (instr_valid_idu_o),
    .instr_ready_idu_i  (instr_ready_idu_i),
    .redir_valid_exeu_i (redir_valid_exeu_i),
    .pc_act_trgt_exeu_i (pc_act_trgt_exeu_i),
    .fetch_err_o        (fetch_err_o),
    .inst_cnt_o         (inst_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // From REQ with immediate handshakes: 4 cycles back to the next state.
  task automatic run_instr(input logic [31:0] data, input logic [31:0] trgt);
    step();
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = data;
    step();
    imem_rsp_valid_i = 1'b0;
    step();
    redir_valid_exeu_i = 1'b1;
    pc_act_trgt_exeu_i = trgt;
    step();
    redir_valid_exeu_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (imem_req_valid_o !== 1'b0 || instr_valid_idu_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: got req=%b iv=%b exp 0 0",
               imem_req_valid_o, instr_valid_idu_o);
    end
    checks++;
    if (imem_req_addr_o !== 32'h8000_0000 || pc_idu_o !== 32'h8000_0000) begin
      errors++;
      $display("FAIL reset_pc: got addr=%h pc=%h exp 80000000",
               imem_req_addr_o, pc_idu_o);
    end
    checks++;
    if (instr_idu_o !== 32'h0 || fetch_err_o !== 1'b0 || inst_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_misc: got instr=%h err=%b cnt=%0d exp 0 0 0",
               instr_idu_o, fetch_err_o, inst_cnt_o);
    end
    rst_n = 1'b0;
  endtask

  task automatic test_first_fetch();
    step();
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0000) begin
      errors++;
      $display("FAIL first_req: got v=%b addr=%h exp 1 80000000",
               imem_req_valid_o, imem_req_addr_o);
    end
    step();
    checks++;
    if (imem_req_valid_o !== 1'b0 || instr_valid_idu_o !== 1'b0) begin
      errors++;
      $display("FAIL first_wait: got req=%b iv=%b exp 0 0",
               imem_req_valid_o, instr_valid_idu_o);
    end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0000_0013;
    step();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (instr_valid_idu_o !== 1'b1 || instr_idu_o !== 32'h0000_0013 ||
        pc_idu_o !== 32'h8000_0000) begin
      errors++;
      $display("FAIL first_deliver: got v=%b i=%h pc=%h exp 1 00000013 80000000",
               instr_valid_idu_o, instr_idu_o, pc_idu_o);
    end
    step();
    checks++;
    if (inst_cnt_o !== 32'd1 || instr_valid_idu_o !== 1'b0) begin
      errors++;
      $display("FAIL first_cnt: got cnt=%0d v=%b exp 1 0",
               inst_cnt_o, instr_valid_idu_o);
    end
  endtask

  task automatic test_sequential();
    redir_valid_exeu_i = 1'b1;
    pc_act_trgt_exeu_i = 32'h8000_0004;
    step();
    redir_valid_exeu_i = 1'b0;
    t0 = cyc;
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0004) begin
      errors++;
      $display("FAIL seq_req1: got v=%b addr=%h exp 1 80000004",
               imem_req_valid_o, imem_req_addr_o);
    end
    run_instr(32'h0040_0093, 32'h8000_0008);
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0008 ||
        cyc - t0 != 4) begin
      errors++;
      $display("FAIL seq_req2: got v=%b addr=%h gap=%0d exp 1 80000008 4",
               imem_req_valid_o, imem_req_addr_o, cyc - t0);
    end
    t0 = cyc;
    run_instr(32'h0080_0093, 32'h8000_000C);
    checks++;
    if (imem_req_addr_o !== 32'h8000_000C || inst_cnt_o !== 32'd3 ||
        cyc - t0 != 4) begin
      errors++;
      $display("FAIL seq_req3: got addr=%h cnt=%0d gap=%0d exp 8000000c 3 4",
               imem_req_addr_o, inst_cnt_o, cyc - t0);
    end
  endtask

  task automatic test_backpressure();
    imem_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_000C) begin
        errors++;
        $display("FAIL bp_req_hold%0d: got v=%b addr=%h exp 1 8000000c",
                 i, imem_req_valid_o, imem_req_addr_o);
      end
    end
    imem_req_ready_i = 1'b1;
    step();
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_req_once: got v=%b exp 0", imem_req_valid_o);
    end
    imem_rsp_valid_i  = 1'b1;
    imem_rsp_data_i   = 32'h00A0_0093;
    instr_ready_idu_i = 1'b0;
    step();
    imem_rsp_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (instr_valid_idu_o !== 1'b1 || instr_idu_o !== 32'h00A0_0093 ||
          pc_idu_o !== 32'h8000_000C || inst_cnt_o !== 32'd3) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b i=%h pc=%h cnt=%0d exp 1 00a00093 8000000c 3",
                 i, instr_valid_idu_o, instr_idu_o, pc_idu_o, inst_cnt_o);
      end
    end
    instr_ready_idu_i = 1'b1;
    step();
    checks++;
    if (instr_valid_idu_o !== 1'b0 || inst_cnt_o !== 32'd4 ||
        imem_req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: got v=%b cnt=%0d req=%b exp 0 4 0",
               instr_valid_idu_o, inst_cnt_o, imem_req_valid_o);
    end
    redir_valid_exeu_i = 1'b1;
    pc_act_trgt_exeu_i = 32'h8000_0010;
    step();
    redir_valid_exeu_i = 1'b0;
  endtask

  task automatic test_branch();
    checks++;
    if (imem_req_addr_o !== 32'h8000_0010 || imem_req_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL br_req: got v=%b addr=%h exp 1 80000010",
               imem_req_valid_o, imem_req_addr_o);
    end
    step();
    redir_valid_exeu_i = 1'b1;
    pc_act_trgt_exeu_i = 32'h8000_0200;
    step();
    redir_valid_exeu_i = 1'b0;
    checks++;
    if (imem_req_valid_o !== 1'b0 || instr_valid_idu_o !== 1'b0 ||
        imem_req_addr_o !== 32'h8000_0010) begin
      errors++;
      $display("FAIL br_spurious: got req=%b iv=%b addr=%h exp 0 0 80000010",
               imem_req_valid_o, instr_valid_idu_o, imem_req_addr_o);
    end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0F00_006F;
    step();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (instr_valid_idu_o !== 1'b1 || pc_idu_o !== 32'h8000_0010 ||
        instr_idu_o !== 32'h0F00_006F) begin
      errors++;
      $display("FAIL br_deliver: got v=%b pc=%h i=%h exp 1 80000010 0f00006f",
               instr_valid_idu_o, pc_idu_o, instr_idu_o);
    end
    step();
    redir_valid_exeu_i = 1'b1;
    pc_act_trgt_exeu_i = 32'h8000_0100;
    step();
    redir_valid_exeu_i = 1'b0;
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0100) begin
      errors++;
      $display("FAIL br_target: got v=%b addr=%h exp 1 80000100",
               imem_req_valid_o, imem_req_addr_o);
    end
  endtask

  task automatic test_halt();
    step();
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0000_0013;
    step();
    imem_rsp_valid_i = 1'b0;
    step();
    halt_i             = 1'b1;
    redir_valid_exeu_i = 1'b1;
    pc_act_trgt_exeu_i = 32'h8000_0020;
    step();
    redir_valid_exeu_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req_valid_o !== 1'b0 || instr_valid_idu_o !== 1'b0) begin
        errors++;
        $display("FAIL halt_idle%0d: got req=%b iv=%b exp 0 0",
                 i, imem_req_valid_o, instr_valid_idu_o);
      end
      step();
    end
    halt_i = 1'b0;
    step();
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0020) begin
      errors++;
      $display("FAIL halt_resume: got v=%b addr=%h exp 1 80000020",
               imem_req_valid_o, imem_req_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req_valid_o !== 1'b0 || imem_req_addr_o !== 32'h8000_0000 ||
        pc_idu_o !== 32'h8000_0000 || instr_idu_o !== 32'h0 ||
        inst_cnt_o !== 32'h0 || fetch_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got req=%b addr=%h pc=%h i=%h cnt=%0d err=%b",
               imem_req_valid_o, imem_req_addr_o, pc_idu_o, instr_idu_o,
               inst_cnt_o, fetch_err_o);
    end
    step();
    rst_n = 1'b0;
    step();
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0000) begin
      errors++;
      $display("FAIL rst_mid_refetch: got v=%b addr=%h exp 1 80000000",
               imem_req_valid_o, imem_req_addr_o);
    end
  endtask

  task automatic test_fault_rsp();
    step();
    imem_rsp_valid_i = 1'b1;
    imem_rsp_err_i   = 1'b1;
    step();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_err_i   = 1'b0;
    redir_valid_exeu_i = 1'b1;
    pc_act_trgt_exeu_i = 32'h8000_0040;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fetch_err_o !== 1'b1 || instr_valid_idu_o !== 1'b0 ||
          imem_req_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL rsp_err%0d: got err=%b iv=%b req=%b exp 1 0 0",
                 i, fetch_err_o, instr_valid_idu_o, imem_req_valid_o);
      end
      step();
    end
    redir_valid_exeu_i = 1'b0;
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    checks++;
    if (fetch_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rsp_err_clear: got err=%b exp 0", fetch_err_o);
    end
  endtask

  task automatic test_fault_misalign();
    step();
    run_instr(32'h0000_0013, 32'h8000_0102);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fetch_err_o !== 1'b1 || imem_req_valid_o !== 1'b0 ||
          inst_cnt_o !== 32'd1) begin
        errors++;
        $display("FAIL misalign%0d: got err=%b req=%b cnt=%0d exp 1 0 1",
                 i, fetch_err_o, imem_req_valid_o, inst_cnt_o);
      end
      step();
    end
  endtask

  initial begin
    errors             = 0;
    checks             = 0;
    cyc                = 0;
    t0                 = 0;
    rst_n              = 1'b1;
    halt_i             = 1'b0;
    imem_req_ready_i   = 1'b1;
    imem_rsp_valid_i   = 1'b0;
    imem_rsp_data_i    = 32'h0;
    imem_rsp_err_i     = 1'b0;
    instr_ready_idu_i  = 1'b1;
    redir_valid_exeu_i = 1'b0;
    pc_act_trgt_exeu_i = 32'h0;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_backpressure();
    test_branch();
    test_halt();
    test_reset_mid();
    test_fault_rsp();
    test_fault_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
